// File: rtl/float_fixed_pkg.sv
// float_fixed_pkg: shared types and helpers for binary32 -> fixed-point conversion.
//
// Contents:
//   EXP_W, MANT_W, EXP_BIAS : binary32 field geometry
//   SH_W                    : width of the signed alignment shift amount
//   fp_class_e              : classification of a binary32 operand
//   fx_flags_t              : {nan, ovf, unf} exception flags
//   s1_payload_t            : decoded operand handed from decode to align/round/saturate
//   fp_decode()             : splits a binary32 word into an s1_payload_t
package float_fixed_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int SH_W     = 10;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic nan;
        logic ovf;
        logic unf;
    } fx_flags_t;

    // sh is the left-shift that turns the integer mantissa into the fixed-point
    // magnitude; negative values mean a right shift with rounding.
    typedef struct packed {
        logic                   sign;
        fp_class_e              cls;
        logic signed [SH_W-1:0] sh;
        logic [MANT_W:0]        mant;
    } s1_payload_t;

    function automatic s1_payload_t fp_decode(input logic [31:0] f, input int frac_bits);
        s1_payload_t      p;
        logic [EXP_W-1:0] e;
        logic [MANT_W-1:0] frac;
        e      = f[MANT_W +: EXP_W];
        frac   = f[MANT_W-1:0];
        p.sign = f[31];
        p.mant = {1'b1, frac};
        // value = mant * 2^(E - bias - MANT_W); scaling by 2^frac_bits folds into the shift
        p.sh   = $signed({2'b00, e}) - $signed(SH_W'(EXP_BIAS + MANT_W))
               + $signed(SH_W'(frac_bits));
        if (e == '0) begin
            p.cls = (frac == '0) ? ZERO : DENORM;
        end else if (e == '1) begin
            p.cls = (frac == '0) ? INF : NAN;
        end else begin
            p.cls = NORMAL;
        end
        return p;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// fixed_round_sat: combinational align / round / saturate stage for a decoded
// binary32 operand. Produces a fixed-point word and mutually exclusive flags.
//
// Parameters:
//   OUT_WIDTH : result width
//   SIGNED    : 1 = two's complement result, 0 = unsigned (negatives clamp to 0)
//   ROUND     : 1 = round half to even, 0 = truncate toward zero
// Ports:
//   op_i    in  s1_payload_t       decoded operand (sign, class, shift, mantissa)
//   data_o  out [OUT_WIDTH-1:0]    fixed-point result
//   flags_o out fx_flags_t         {nan, ovf, unf}
module fixed_round_sat
    import float_fixed_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int SIGNED    = 1,
    parameter int ROUND     = 1
) (
    input  s1_payload_t           op_i,
    output logic [OUT_WIDTH-1:0]  data_o,
    output fx_flags_t             flags_o
);

    localparam int PW   = OUT_WIDTH + 1;          // pre-round magnitude, one spare bit
    localparam int RW   = OUT_WIDTH + 2;          // post-round magnitude incl. carry
    localparam int BW   = PW + MANT_W + 1;        // left-shift workspace
    localparam int NMAX = MANT_W + 3;             // right shifts beyond this are all sticky
    localparam int SW   = MANT_W + 1 + NMAX;      // mantissa plus guard/sticky field

    localparam logic [OUT_WIDTH-1:0] POS_LIM = (SIGNED != 0) ?
        {1'b0, {(OUT_WIDTH-1){1'b1}}} : {OUT_WIDTH{1'b1}};
    localparam logic [OUT_WIDTH-1:0] NEG_LIM = (SIGNED != 0) ?
        {1'b1, {(OUT_WIDTH-1){1'b0}}} : {OUT_WIDTH{1'b0}};

    logic [BW-1:0]   big;
    logic [SW-1:0]   shr;
    logic [SH_W-1:0] n;
    logic [4:0]      n_c;
    logic [PW-1:0]   pre;
    logic            pre_ovf;
    logic            guard;
    logic            sticky;
    logic            inc;
    logic [RW-1:0]   rounded;
    logic [RW-1:0]   lim;

    // Alignment: produce the truncated magnitude plus guard/sticky.
    always_comb begin
        big     = '0;
        shr     = '0;
        n       = '0;
        n_c     = '0;
        pre     = '0;
        pre_ovf = 1'b0;
        guard   = 1'b0;
        sticky  = 1'b0;
        if (!op_i.sh[SH_W-1]) begin
            // The mantissa MSB is always set, so a shift of OUT_WIDTH or more cannot fit.
            if ($unsigned(op_i.sh) >= SH_W'(OUT_WIDTH)) begin
                pre_ovf = 1'b1;
            end else begin
                big     = BW'(op_i.mant) << $unsigned(op_i.sh);
                pre     = big[PW-1:0];
                pre_ovf = |big[BW-1:PW];
            end
        end else begin
            n   = $unsigned(-op_i.sh);
            // Clamping to NMAX leaves guard=0 and the whole mantissa in sticky.
            n_c = (n > SH_W'(NMAX)) ? 5'(NMAX) : n[4:0];
            shr = {op_i.mant, {NMAX{1'b0}}} >> n_c;
            pre    = PW'(shr[SW-1:NMAX]);
            guard  = shr[NMAX-1];
            sticky = |shr[NMAX-2:0];
        end
    end

    // Rounding and saturation. lim is the largest magnitude representable for
    // this sign: negatives get one extra code in signed mode, none in unsigned.
    always_comb begin
        inc     = (ROUND != 0) && guard && (sticky || pre[0]);
        rounded = RW'(pre) + RW'(inc);
        if (SIGNED != 0) begin
            lim = RW'(POS_LIM) + RW'(op_i.sign);
        end else begin
            lim = op_i.sign ? '0 : RW'(POS_LIM);
        end

        data_o  = '0;
        flags_o = '0;
        case (op_i.cls)
            NAN: begin
                data_o      = POS_LIM;
                flags_o.nan = 1'b1;
            end
            INF: begin
                data_o      = op_i.sign ? NEG_LIM : POS_LIM;
                flags_o.ovf = 1'b1;
            end
            DENORM: begin
                flags_o.unf = 1'b1;
            end
            NORMAL: begin
                if (pre_ovf || (rounded > lim)) begin
                    data_o      = op_i.sign ? NEG_LIM : POS_LIM;
                    flags_o.ovf = 1'b1;
                end else if (rounded == '0) begin
                    flags_o.unf = 1'b1;
                end else if ((SIGNED != 0) && op_i.sign) begin
                    data_o = -rounded[OUT_WIDTH-1:0];
                end else begin
                    data_o = rounded[OUT_WIDTH-1:0];
                end
            end
            default: begin
                data_o  = '0;
                flags_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: two-stage pipelined IEEE-754 binary32 to fixed-point
// converter producing Q(OUT_WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS operands.
// Stage 1 decodes the float, stage 2 aligns, rounds and saturates.
//
// Ports:
//   clk       in  1          clock
//   rst       in  1          asynchronous active-high reset
//   in_valid  in  1          input float valid
//   in_ready  out 1          converter accepts input this cycle
//   in_data   in  32         IEEE-754 binary32
//   out_valid out 1          result valid
//   out_ready in  1          downstream accepts result
//   out_data  out OUT_WIDTH  fixed-point result
//   out_flags out 3          {nan, ovf, unf}
//
// Handshake: a beat transfers on a rising clk edge where valid && ready. The
// pipeline advances as one unit when en = !out_valid || out_ready; in_ready
// equals en and never looks at in_valid. With en low every stage holds, so the
// output word stays stable until it is taken. Latency 2, throughput 1/cycle.
module float_to_fixed_pipe
    import float_fixed_pkg::*;
#(
    parameter int OUT_WIDTH       = 32,
    parameter int FRACTIONAL_BITS = 30,
    parameter int SIGNED          = 1,
    parameter int ROUND           = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [2:0]           out_flags
);

    logic                 en;
    s1_payload_t          s1_d;
    s1_payload_t          s1_q;
    logic                 s1_valid_q;
    logic [OUT_WIDTH-1:0] s2_data;
    fx_flags_t            s2_flags;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    fx_flags_t            out_flags_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign s1_d     = fp_decode(in_data, FRACTIONAL_BITS);

    fixed_round_sat #(
        .OUT_WIDTH (OUT_WIDTH),
        .SIGNED    (SIGNED),
        .ROUND     (ROUND)
    ) u_round_sat (
        .op_i    (s1_q),
        .data_o  (s2_data),
        .flags_o (s2_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            // Payload registers only load on real beats; bubbles leave them alone.
            if (in_valid) begin
                s1_q <= s1_d;
            end
            if (s1_valid_q) begin
                out_data_q  <= s2_data;
                out_flags_q <= s2_flags;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Bench for float_to_fixed_pipe: three instances (signed+RNE, signed+truncate,
// unsigned+RNE) share one input stream and one out_ready and run in lockstep.
module tb_float_to_fixed_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [31:0] od  [3];
    logic [2:0]  ofl [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] vecs [28];
    bit          sgn_t [3] = '{1'b1, 1'b1, 1'b0};
    bit          rnd_t [3] = '{1'b1, 1'b0, 1'b1};
    bit          hold_prev = 1'b0;
    bit          bp_seen   = 1'b0;
    logic [31:0] prev_d;
    logic [2:0]  prev_f;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    float_to_fixed_pipe #(.OUT_WIDTH(32), .FRACTIONAL_BITS(30), .SIGNED(1), .ROUND(1)) dut_sr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_flags(ofl[0]));
    float_to_fixed_pipe #(.OUT_WIDTH(32), .FRACTIONAL_BITS(30), .SIGNED(1), .ROUND(0)) dut_st (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_flags(ofl[1]));
    float_to_fixed_pipe #(.OUT_WIDTH(32), .FRACTIONAL_BITS(30), .SIGNED(0), .ROUND(1)) dut_ur (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_flags(ofl[2]));

    // ---------------- reference model ----------------
    // Exact value is mant * 2^sh with sh = E - 150 + 30; rounding is decided
    // from the exact remainder against one half of the result LSB.
    function automatic void model(input logic [31:0] f, input bit sgn, input bit rnd,
                                  output logic [31:0] d, output logic [2:0] fl);
        logic [255:0] m, q, r, half, mag, plim;
        int e, sh, n;
        e    = int'(f[30:23]);
        plim = sgn ? ((256'd1 << 31) - 256'd1) : ((256'd1 << 32) - 256'd1);
        d    = 32'h0;
        fl   = 3'b000;
        mag  = '0;
        if (e == 255) begin
            if (f[22:0] != 23'd0) begin
                d  = plim[31:0];
                fl = 3'b100;
            end else begin
                fl = 3'b010;
                d  = !f[31] ? plim[31:0] : (sgn ? 32'h8000_0000 : 32'h0);
            end
            return;
        end
        if (e == 0) begin
            fl = (f[22:0] != 23'd0) ? 3'b001 : 3'b000;
            return;
        end
        m  = 256'({1'b1, f[22:0]});
        sh = e - 150 + 30;
        if (sh >= 0) begin
            mag = m << sh;
        end else begin
            n    = -sh;
            q    = m >> n;
            r    = m - (q << n);
            half = 256'd1 << (n - 1);
            if (rnd && ((r > half) || ((r == half) && q[0]))) q = q + 256'd1;
            mag = q;
        end
        if (f[31] && !sgn) begin
            fl = (mag != 0) ? 3'b010 : 3'b001;
        end else if (f[31]) begin
            if (mag > (256'd1 << 31)) begin
                d  = 32'h8000_0000;
                fl = 3'b010;
            end else begin
                d  = -(mag[31:0]);
                fl = (mag == 0) ? 3'b001 : 3'b000;
            end
        end else if (mag > plim) begin
            d  = plim[31:0];
            fl = 3'b010;
        end else begin
            d  = mag[31:0];
            fl = (mag == 0) ? 3'b001 : 3'b000;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_pin(input string name, input logic [31:0] f, input bit sgn, input bit rnd,
                             input logic [31:0] want_d, input logic [2:0] want_f);
        logic [31:0] d;
        logic [2:0]  fl;
        model(f, sgn, rnd, d, fl);
        chk({name, "_data"}, 64'(d), 64'(want_d));
        chk({name, "_flags"}, 64'(fl), 64'(want_f));
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [31:0] f, ed;
        logic [2:0]  ef;
        if (rst) begin
            hold_prev = 1'b0;
            exp_q.delete();
        end else begin
            chk("in_ready_rule", 64'(ir[0]), 64'(!ov[0] || out_ready));
            for (int k = 1; k < 3; k++) begin
                chk("lockstep", 64'({ov[k], ir[k]}), 64'({ov[0], ir[0]}));
            end
            if (!ir[0]) bp_seen = 1'b1;
            if (hold_prev) begin
                chk("hold_stable", 64'({ov[0], ofl[0], od[0]}), 64'({1'b1, prev_f, prev_d}));
            end
            hold_prev = ov[0] && !out_ready;
            prev_d    = od[0];
            prev_f    = ofl[0];
            if (ov[0] && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got data %h expected no output", od[0]);
                end else begin
                    f = exp_q.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        model(f, sgn_t[k], rnd_t[k], ed, ef);
                        chk($sformatf("out%0d_in%h", k, f), 64'({ofl[k], od[k]}), 64'({ef, ed}));
                    end
                end
            end
            if (in_valid && ir[0]) exp_q.push_back(in_data);
        end
    end

    // ---------------- driver ----------------
    // Entered and left at #1 after a rising edge. out_ready is low on cycles lo..hi.
    task automatic stream(input int first, input int cnt, input int lo, input int hi);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        while (((idx < cnt) || (exp_q.size() != 0)) && (cyc < 300)) begin
            in_valid  = (idx < cnt);
            in_data   = (idx < cnt) ? vecs[first + idx] : 32'h0;
            out_ready = !((cyc >= lo) && (cyc <= hi));
            @(negedge clk);
            acc = in_valid && ir[0];
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_drained", 64'({idx, exp_q.size()}), 64'({cnt, 32'd0}));
    endtask

    initial begin
        vecs = '{32'h3F800000, 32'hBF800000, 32'hC0000000, 32'h40000000, 32'hFF800000,
                 32'h7FC00000, 32'h00000001, 32'h30000000, 32'h30400000, 32'h80000000,
                 32'h7F800000, 32'h00000000, 32'h3FC00000, 32'h30C00000, 32'h3EAAAAAB,
                 32'h3F7FFFFF, 32'hC0000001, 32'h30800000, 32'h2F800000, 32'h00800000,
                 32'h7F7FFFFF, 32'h3FFFFFFF, 32'hB0400000, 32'h30200000, 32'h30A00000,
                 32'h30E00000, 32'h31200000, 32'h31600000};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;

        // hand-computed expectations pinning the model
        check_pin("one",         32'h3F800000, 1, 1, 32'h40000000, 3'b000);
        check_pin("neg_one",     32'hBF800000, 1, 1, 32'hC0000000, 3'b000);
        check_pin("neg_two",     32'hC0000000, 1, 1, 32'h80000000, 3'b000);
        check_pin("two",         32'h40000000, 1, 1, 32'h7FFFFFFF, 3'b010);
        check_pin("neg_inf",     32'hFF800000, 1, 1, 32'h80000000, 3'b010);
        check_pin("nan",         32'h7FC00000, 1, 1, 32'h7FFFFFFF, 3'b100);
        check_pin("denorm",      32'h00000001, 1, 1, 32'h00000000, 3'b001);
        check_pin("half_lsb",    32'h30000000, 1, 1, 32'h00000000, 3'b001);
        check_pin("three_q_lsb", 32'h30400000, 1, 1, 32'h00000001, 3'b000);
        check_pin("trunc",       32'h30400000, 1, 0, 32'h00000000, 3'b001);
        check_pin("uns_neg",     32'hBF800000, 0, 1, 32'h00000000, 3'b010);
        check_pin("uns_negzero", 32'h80000000, 0, 1, 32'h00000000, 3'b000);
        check_pin("tie_2p5",     32'h31200000, 1, 1, 32'h00000002, 3'b000);
        check_pin("tie_3p5",     32'h31600000, 1, 1, 32'h00000004, 3'b000);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov), 64'(3'b000));
        chk("rst_out_data",  64'(od[0]), 64'h0);
        chk("rst_out_flags", 64'(ofl[0]), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;

        // directed streams
        stream(0, 28, -1, -2);
        stream(0, 6, 3, 7);
        chk("in_ready_dropped", 64'(bp_seen), 64'd1);
        stream(20, 8, 1, 2);

        // reset with two items in flight
        in_valid  = 1'b1;
        in_data   = vecs[12];
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_data = vecs[13];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("inflight_valid", 64'(ov[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(ov), 64'(3'b000));
        chk("async_rst_data",  64'(od[0]), 64'h0);
        chk("async_rst_flags", 64'(ofl[0]), 64'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vecs[14];
        @(negedge clk);
        chk("post_rst_ready", 64'(ir[0]), 64'd1);
        chk("post_rst_no_out", 64'(ov[0]), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_cycle1", 64'(ov[0]), 64'd0);
        @(negedge clk);
        chk("latency_cycle2", 64'(ov[0]), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
